// File: rtl/instruction_fetch_pkg.sv
// Shared processor definitions: word width, reset fetch address and the
// fetch FSM state encoding (also consumed by control_unit).
package instruction_fetch_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one memory read at a time, holds the
// returned word for control_unit, and handles branch redirects that may
// arrive while a read is still outstanding.
//
//   state | meaning
//   IDLE  | one cycle after reset, pc settles (may take a branch)
//   FETCH | mem_req high, waiting for mem_ack at mem_addr
//   HOLD  | instr_valid high, waiting for instr_ready or a branch
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              clear,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_data,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] pc;
  // Set when a branch lands while a read is in flight; that read's data
  // must be thrown away when its ack finally arrives.
  logic              drop;

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: if (mem_ack && !drop && !branch_taken) state_next = ST_HOLD;
      ST_HOLD:  if (instr_ready || branch_taken) state_next = ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    mem_req     = (state == ST_FETCH);
    instr_valid = (state == ST_HOLD);
  end

  // Program counter, request address, held instruction and drop flag.
  // mem_addr is only rewritten when a new request starts, so it stays
  // constant for the lifetime of each request.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc       <= RESET_PC;
      mem_addr <= '0;
      instr    <= '0;
      instr_pc <= '0;
      drop     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (branch_taken) begin
            pc       <= branch_target;
            mem_addr <= branch_target;
          end else begin
            mem_addr <= pc;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            if (branch_taken) begin
              pc       <= branch_target;
              mem_addr <= branch_target;
              drop     <= 1'b0;
            end else if (drop) begin
              drop     <= 1'b0;
              mem_addr <= pc;
            end else begin
              instr    <= mem_data;
              instr_pc <= mem_addr;
              pc       <= mem_addr + 16'd1;
            end
          end else if (branch_taken) begin
            pc   <= branch_target;
            drop <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (branch_taken) begin
            pc       <= branch_target;
            mem_addr <= branch_target;
          end else if (instr_ready) begin
            mem_addr <= pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory responder, a stimulus driver with a
// program-flow reference model, and a monitor checking every transfer
// against the model's expected (instr, pc) queue.
module tb_instruction_fetch;

  logic        clock;
  logic        clear;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_target;

  logic        clear2;
  logic        mem_req2;
  logic [15:0] mem_addr2;
  logic        ack2;
  logic [15:0] data2;
  logic [15:0] instr2;
  logic [15:0] instr_pc2;
  logic        instr_valid2;
  logic        ready2;
  logic        branch2;
  logic [15:0] target2;

  instruction_fetch dut (
    .clock(clock), .clear(clear), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  instruction_fetch #(.RESET_PC(16'hFFFF)) dut2 (
    .clock(clock), .clear(clear2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(ack2), .mem_data(data2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .instr_ready(ready2),
    .branch_taken(branch2), .branch_target(target2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;
  int n_xfer = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Memory contents seen by the fetch unit.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0325;
    if (a == 16'h0001) return 16'h012E;
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  // ---------------- memory responder ----------------
  int          lat = 1;
  logic        lat_rand = 1'b0;
  logic        spurious = 1'b0;
  logic        stale_ack = 1'b0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_log[$];

  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
  end

  always @(negedge clock) begin
    mem_ack  = 1'b0;
    mem_data = 16'($urandom);
    if (stale_ack) begin
      busy     = 1'b0;
      mem_ack  = 1'b1;
      mem_data = 16'hDEAD;
    end else if (!clear) begin
      busy = 1'b0;
    end else if (mem_req) begin
      if (!busy) begin
        busy     = 1'b1;
        req_addr = mem_addr;
        req_log.push_back(mem_addr);
        cnt      = lat_rand ? int'($urandom_range(0, 3)) : lat;
      end else begin
        check("addr_stable", mem_addr, req_addr);
      end
      if (cnt == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem_fn(req_addr);
        busy     = 1'b0;
      end else begin
        cnt--;
      end
    end else begin
      busy = 1'b0;
      if (spurious && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
    end
  end

  // ---------------- reference model / driver ----------------
  logic [15:0] exp_pc = 16'h0000;
  logic [31:0] exp_q[$];

  // Called once per falling edge. The next instruction presented is always
  // exp_pc; a transfer advances it by one, a branch replaces it.
  task automatic apply(input logic r, input logic b, input logic [15:0] t);
    if (instr_valid && r) begin
      exp_q.push_back({mem_fn(exp_pc), exp_pc});
      exp_pc = exp_pc + 16'd1;
    end
    if (b) exp_pc = t;
    instr_ready   = r;
    branch_taken  = b;
    branch_target = b ? t : 16'($urandom);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (instr_valid && instr_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check1("unexpected_xfer", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("xfer_instr", instr, e[31:16]);
          check("xfer_pc", instr_pc, e[15:0]);
        end
      end
    end
  end

  // ---------------- RESET_PC = FFFF instance ----------------
  initial begin
    clear2 = 1'b0; ready2 = 1'b0; ack2 = 1'b0; data2 = '0;
    branch2 = 1'b0; target2 = '0;
    repeat (2) @(negedge clock);
    @(negedge clock);
    check("rst2_addr", mem_addr2, 16'h0000);
    check1("rst2_req", mem_req2, 1'b0);
    clear2 = 1'b1;
    @(negedge clock);
    check1("pc_ffff_req", mem_req2, 1'b1);
    check("pc_ffff_addr", mem_addr2, 16'hFFFF);
    ack2 = 1'b1; data2 = 16'h1234;
    @(negedge clock);
    ack2 = 1'b0;
    check1("pc_ffff_valid", instr_valid2, 1'b1);
    check("pc_ffff_instr", instr2, 16'h1234);
    check("pc_ffff_ipc", instr_pc2, 16'hFFFF);
    ready2 = 1'b1;
    @(negedge clock);
    ready2 = 1'b0;
    check1("wrap_req", mem_req2, 1'b1);
    check("wrap_addr", mem_addr2, 16'h0000);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        found;
    logic [15:0] t;
    clear = 1'b0;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(negedge clock);
    check1("rst_req", mem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_ipc", instr_pc, 16'h0000);

    // release, then two sequential fetches with 1-cycle memory
    @(negedge clock);
    clear = 1'b1;
    apply(1'b1, 1'b0, 16'h0);
    #1 check1("idle_after_release", mem_req, 1'b0);
    @(negedge clock);
    check1("first_req", mem_req, 1'b1);
    check("first_addr", mem_addr, 16'h0000);
    apply(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      apply(1'b1, 1'b0, 16'h0);
    end
    check("log0", req_log[0], 16'h0000);
    check("log1", req_log[1], 16'h0001);

    // stall in HOLD with instr_ready low
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      apply(1'b0, 1'b0, 16'h0);
      found = instr_valid;
    end
    check1("hold_reached", found, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check1("stall_valid", instr_valid, 1'b1);
      check1("stall_noreq", mem_req, 1'b0);
      check("stall_instr", instr, mem_fn(exp_pc));
      check("stall_ipc", instr_pc, exp_pc);
      apply(1'b0, 1'b0, 16'h0);
    end
    lat = 2;
    @(negedge clock);
    apply(1'b1, 1'b0, 16'h0);

    // branch to 0x0040 while the request to 0x0003 is outstanding
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (mem_req && mem_addr == 16'h0003) begin
        found = 1'b1;
        apply(1'b1, 1'b1, 16'h0040);
      end else begin
        apply(1'b1, 1'b0, 16'h0);
      end
    end
    check1("req3_seen", found, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check1("drop_novalid", instr_valid, 1'b0);
      apply(1'b1, 1'b0, 16'h0);
    end
    @(negedge clock);
    check("redirect_addr", req_log[req_log.size()-1], 16'h0040);
    check("orig_addr", req_log[req_log.size()-2], 16'h0003);
    apply(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      apply(1'b1, 1'b0, 16'h0);
    end

    // branch coincident with ack, then branch in HOLD with ready
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      found = !mem_req;
      apply(1'b1, 1'b0, 16'h0);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (mem_req) begin
        found = 1'b1;
        apply(1'b1, 1'b1, 16'h0100);
      end else begin
        apply(1'b1, 1'b0, 16'h0);
      end
    end
    check1("ack_branch_seen", found, 1'b1);
    @(negedge clock);
    check1("ackbr_req", mem_req, 1'b1);
    check("ackbr_addr", mem_addr, 16'h0100);
    check1("ackbr_novalid", instr_valid, 1'b0);
    apply(1'b1, 1'b0, 16'h0);
    @(negedge clock);
    check1("holdbr_valid", instr_valid, 1'b1);
    check("holdbr_ipc", instr_pc, 16'h0100);
    apply(1'b1, 1'b1, 16'h0200);
    lat = 3;
    @(negedge clock);
    check1("holdbr_req", mem_req, 1'b1);
    check("holdbr_addr", mem_addr, 16'h0200);
    check1("holdbr_novalid", instr_valid, 1'b0);
    apply(1'b0, 1'b0, 16'h0);

    // reset mid-FETCH, stale ack right after release
    @(negedge clock);
    apply(1'b0, 1'b0, 16'h0);
    #1 clear = 1'b0;
    exp_pc = 16'h0000;
    #1;
    check1("midrst_req", mem_req, 1'b0);
    check1("midrst_valid", instr_valid, 1'b0);
    check("midrst_addr", mem_addr, 16'h0000);
    check("midrst_instr", instr, 16'h0000);
    check("midrst_ipc", instr_pc, 16'h0000);
    @(negedge clock);
    apply(1'b0, 1'b0, 16'h0);
    #1 stale_ack = 1'b1;
    @(negedge clock);
    clear = 1'b1;
    apply(1'b0, 1'b0, 16'h0);
    #1 stale_ack = 1'b0;
    @(negedge clock);
    check1("stale_req", mem_req, 1'b1);
    check("stale_addr", mem_addr, 16'h0000);
    check1("stale_novalid", instr_valid, 1'b0);
    check("stale_instr", instr, 16'h0000);
    apply(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      apply(1'b1, 1'b0, 16'h0);
    end

    // branch while IDLE right after reset
    @(negedge clock);
    apply(1'b0, 1'b0, 16'h0);
    #1 clear = 1'b0;
    exp_pc = 16'h0000;
    @(negedge clock);
    apply(1'b0, 1'b0, 16'h0);
    @(negedge clock);
    clear = 1'b1;
    apply(1'b1, 1'b1, 16'h0500);
    @(negedge clock);
    check1("idlebr_req", mem_req, 1'b1);
    check("idlebr_addr", mem_addr, 16'h0500);
    apply(1'b1, 1'b0, 16'h0);

    // randomized traffic
    lat_rand = 1'b1;
    spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      t = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, t);
    end
    spurious = 1'b0;
    lat_rand = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      apply(1'b1, 1'b0, 16'h0);
    end
    @(negedge clock);
    apply(1'b0, 1'b0, 16'h0);
    #3;
    check1("queue_drained", exp_q.size() == 0, 1'b1);
    check1("enough_xfers", n_xfer > 150, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
